// File: rtl/vfm_io_arbiter_pkg.sv
// Types, widths and helpers shared by vfm_io_arbiter and its round-robin picker.
`include "vfm_defs.vh"

package vfm_io_arbiter_pkg;

  localparam int ADDR_W      = `VFM_ADDR_W;
  localparam int DEF_DATA_W  = `VFM_DATA_W;
  localparam int DEF_N_PORTS = `VFM_N_PORTS;

  typedef enum logic {
    ST_IDLE  = `VFM_ST_IDLE,
    ST_WRITE = `VFM_ST_WRITE
  } state_e;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vfm_defs.vh
// Shared FSM encodings and default widths for the vfm I/O arbiter.
`ifndef VFM_DEFS_VH
`define VFM_DEFS_VH

`define VFM_ST_IDLE   1'b0
`define VFM_ST_WRITE  1'b1

`define VFM_DATA_W    14
`define VFM_N_PORTS   16
`define VFM_ADDR_W    4

`endif

// File: rtl/vfm_rr_pick.sv
// Round-robin winner search starting just above the last winner, wrapping at N_REQ.
// Zero latency combinational function; no flow control of its own.
module vfm_rr_pick
  import vfm_io_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic             o_vld,
  output logic [N_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0] o_idx
);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    o_vld    = 1'b0;
    o_onehot = '0;
    o_idx    = '0;
    w_cand   = i_last;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = (w_cand == IDX_W'(N_REQ - 1)) ? '0 : w_cand + IDX_W'(1);
      if (!o_vld && i_req[w_cand]) begin
        o_vld            = 1'b1;
        o_onehot[w_cand] = 1'b1;
        o_idx            = w_cand;
      end
    end
  end

endmodule

// File: rtl/vfm_io_arbiter.sv
// Round-robin arbiter granting N_REQ requesters write access to a bank of registered output ports.
// Grant one cycle after request, write+ack the cycle after; no backpressure, requesters hold until ack.
module vfm_io_arbiter
  import vfm_io_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int N_PORTS = DEF_N_PORTS
) (
  input  logic                      Clock_pin,
  input  logic                      Resetn_pin,
  input  logic [N_REQ-1:0]          Req_in,
  input  logic [N_REQ*ADDR_W-1:0]   Addr_in,
  input  logic [N_REQ*DATA_W-1:0]   Data_in,
  output logic [N_REQ-1:0]          Grant_out,
  output logic [N_REQ-1:0]          Ack_out,
  output logic [N_PORTS*DATA_W-1:0] Out_bus,
  output logic [N_PORTS-1:0]        Write_strobe
);

  localparam int IDX_W = idx_w(N_REQ);

  state_e             r_state;
  logic [N_REQ-1:0]   r_grant;
  logic [N_REQ-1:0]   r_ack;
  logic [N_PORTS-1:0] r_strobe;
  logic [DATA_W-1:0]  r_port [N_PORTS];
  logic [IDX_W-1:0]   r_last;
  logic [IDX_W-1:0]   r_win;

  logic               w_pick_vld;
  logic [N_REQ-1:0]   w_pick_oh;
  logic [IDX_W-1:0]   w_pick_idx;
  logic [ADDR_W-1:0]  w_addr_arr [N_REQ];
  logic [DATA_W-1:0]  w_data_arr [N_REQ];
  logic [ADDR_W-1:0]  w_wr_addr;
  logic [DATA_W-1:0]  w_wr_data;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign w_addr_arr[i] = Addr_in[i*ADDR_W +: ADDR_W];
    assign w_data_arr[i] = Data_in[i*DATA_W +: DATA_W];
  end

  // Address and data are only consumed in the WRITE cycle, from the held winner.
  assign w_wr_addr = w_addr_arr[r_win];
  assign w_wr_data = w_data_arr[r_win];

  vfm_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req    (Req_in),
    .i_last   (r_last),
    .o_vld    (w_pick_vld),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx)
  );

  always_ff @(posedge Clock_pin) begin
    if (!Resetn_pin) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_ack    <= '0;
      r_strobe <= '0;
      r_last   <= IDX_W'(N_REQ - 1);
      r_win    <= '0;
      for (int p = 0; p < N_PORTS; p++) begin
        r_port[p] <= '0;
      end
    end else begin
      r_ack    <= '0;
      r_strobe <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_vld) begin
            r_grant <= w_pick_oh;
            r_win   <= w_pick_idx;
            r_state <= ST_WRITE;
          end else begin
            r_grant <= '0;
          end
        end
        ST_WRITE: begin
          // A withdrawn request completes the grant silently and keeps the old rotation point.
          if (Req_in[r_win]) begin
            r_port[w_wr_addr]   <= w_wr_data;
            r_strobe[w_wr_addr] <= 1'b1;
            r_ack[r_win]        <= 1'b1;
            r_last              <= r_win;
          end
          r_grant <= '0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_grant <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar p = 0; p < N_PORTS; p++) begin : g_flat
    assign Out_bus[p*DATA_W +: DATA_W] = r_port[p];
  end

  assign Grant_out    = r_grant;
  assign Ack_out      = r_ack;
  assign Write_strobe = r_strobe;

endmodule

// File: tb/tb_vfm_io_arbiter.sv
// Directed bench for vfm_io_arbiter with a rule-level reference model checked every cycle.
module tb_vfm_io_arbiter;

  localparam int N_REQ   = 4;
  localparam int DATA_W  = 14;
  localparam int N_PORTS = 16;
  localparam int AW      = 4;
  localparam int OW      = N_PORTS * DATA_W;

  logic                    clk  = 1'b0;
  logic                    rstn = 1'b0;
  logic [N_REQ-1:0]        req  = '0;
  logic [N_REQ*AW-1:0]     addr = '0;
  logic [N_REQ*DATA_W-1:0] data = '0;
  logic [N_REQ-1:0]        grant;
  logic [N_REQ-1:0]        ack;
  logic [OW-1:0]           obus;
  logic [N_PORTS-1:0]      strobe;

  always #5 clk = ~clk;

  vfm_io_arbiter #(
    .N_REQ   (N_REQ),
    .DATA_W  (DATA_W),
    .N_PORTS (N_PORTS)
  ) dut (
    .Clock_pin    (clk),
    .Resetn_pin   (rstn),
    .Req_in       (req),
    .Addr_in      (addr),
    .Data_in      (data),
    .Grant_out    (grant),
    .Ack_out      (ack),
    .Out_bus      (obus),
    .Write_strobe (strobe)
  );

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: last winner, pending grant, port contents
  int                m_last = N_REQ - 1;
  int                m_pend = -1;
  int                cyc    = 0;
  logic [DATA_W-1:0] m_port [N_PORTS];
  logic [N_REQ-1:0]  m_grant  = '0;
  logic [N_REQ-1:0]  m_ack    = '0;
  logic [N_PORTS-1:0] m_strobe = '0;

  always @(posedge clk) begin
    int a;
    cyc++;
    m_ack    = '0;
    m_strobe = '0;
    if (!rstn) begin
      m_grant = '0;
      m_last  = N_REQ - 1;
      m_pend  = -1;
      foreach (m_port[p]) m_port[p] = '0;
    end else if (m_pend >= 0) begin
      if (req[m_pend]) begin
        a              = int'(addr[m_pend*AW +: AW]);
        m_port[a]      = data[m_pend*DATA_W +: DATA_W];
        m_ack[m_pend]  = 1'b1;
        m_strobe[a]    = 1'b1;
        m_last         = m_pend;
      end
      m_pend  = -1;
      m_grant = '0;
    end else begin
      m_grant = '0;
      for (int k = 1; k <= N_REQ; k++) begin
        if (m_pend < 0 && req[(m_last + k) % N_REQ]) begin
          m_pend          = (m_last + k) % N_REQ;
          m_grant[m_pend] = 1'b1;
        end
      end
    end
  end

  function automatic logic [OW-1:0] model_bus();
    logic [OW-1:0] v;
    for (int p = 0; p < N_PORTS; p++) v[p*DATA_W +: DATA_W] = m_port[p];
    return v;
  endfunction

  int g_log [$];
  int a_cyc [$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("grant", OW'(grant), OW'(m_grant));
      check("ack", OW'(ack), OW'(m_ack));
      check("strobe", OW'(strobe), OW'(m_strobe));
      check("out_bus", obus, model_bus());
      check("ack_onehot0", OW'($countones(ack) <= 1), OW'(1'b1));
      check("strobe_onehot0", OW'($countones(strobe) <= 1), OW'(1'b1));
      for (int i = 0; i < N_REQ; i++) if (grant[i]) g_log.push_back(i);
      if (ack != '0) a_cyc.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic on, input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
    req[i]                   = on;
    addr[i*AW +: AW]         = a;
    data[i*DATA_W +: DATA_W] = d;
  endtask

  function automatic logic [OW-1:0] put(input logic [OW-1:0] v, input int p, input logic [DATA_W-1:0] d);
    v[p*DATA_W +: DATA_W] = d;
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] sl(input logic [OW-1:0] v, input int p);
    return v[p*DATA_W +: DATA_W];
  endfunction

  initial begin
    int exp_order [6];
    exp_order = '{0, 1, 2, 3, 0, 1};

    // Reset values
    rstn = 1'b0;
    tick(1);
    chk_en = 1'b1;
    tick(1);
    check("rst_grant", OW'(grant), OW'(4'b0000));
    check("rst_out_bus", obus, '0);
    rstn = 1'b1;

    // Single write: requester 0 to port 3
    set_req(0, 1'b1, 4'd3, 14'h0A5);
    tick(1);
    check("t1_grant", OW'(grant), OW'(4'b0001));
    tick(1);
    check("t1_ack", OW'(ack), OW'(4'b0001));
    check("t1_strobe", OW'(strobe), OW'(16'h0008));
    set_req(0, 1'b0, 4'd3, 14'h0A5);
    tick(1);
    check("t1_out3", OW'(sl(obus, 3)), OW'(14'h0A5));

    // Fairness with all four requesting
    rstn = 1'b0;
    tick(1);
    rstn = 1'b1;
    g_log.delete();
    a_cyc.delete();
    for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, AW'(i), DATA_W'(32'h100 + i));
    tick(12);
    req = '0;
    tick(2);
    check("rr_grant_count", OW'(g_log.size()), OW'(6));
    for (int i = 0; i < 6 && i < g_log.size(); i++)
      check("rr_order", OW'(g_log[i]), OW'(exp_order[i]));
    check("rr_ack_count", OW'(a_cyc.size()), OW'(6));
    for (int i = 1; i < a_cyc.size(); i++)
      check("rr_ack_spacing", OW'(a_cyc[i] - a_cyc[i-1]), OW'(2));

    // Two requesters to the same port: last acknowledged wins
    rstn = 1'b0;
    tick(1);
    rstn = 1'b1;
    set_req(1, 1'b1, 4'd5, 14'h111);
    set_req(2, 1'b1, 4'd5, 14'h222);
    tick(2);
    check("t3_out5_first", OW'(sl(obus, 5)), OW'(14'h111));
    set_req(1, 1'b0, 4'd5, 14'h111);
    tick(2);
    check("t3_out5_second", OW'(sl(obus, 5)), OW'(14'h222));
    req[2] = 1'b0;

    // Withdrawn request in the write cycle
    set_req(3, 1'b1, 4'd7, 14'h333);
    tick(1);
    check("t4_grant", OW'(grant), OW'(4'b1000));
    req[3] = 1'b0;
    tick(1);
    check("t4_no_ack", OW'(ack), OW'(4'b0000));
    check("t4_no_strobe", OW'(strobe), OW'(16'h0000));
    check("t4_bus_kept", obus, put('0, 5, 14'h222));
    set_req(0, 1'b1, 4'd9, 14'h0AA);
    set_req(3, 1'b1, 4'd7, 14'h333);
    tick(1);
    check("t4_rearb_grant", OW'(grant), OW'(4'b1000));
    tick(1);
    req[3] = 1'b0;
    tick(2);
    req[0] = 1'b0;
    check("t4_bus", obus, put(put(put('0, 5, 14'h222), 7, 14'h333), 9, 14'h0AA));

    // Reset during a write cancels it and restores requester 0 priority
    set_req(2, 1'b1, 4'd1, 14'h3FFF);
    tick(1);
    check("t5_grant", OW'(grant), OW'(4'b0100));
    rstn = 1'b0;
    set_req(0, 1'b1, 4'd4, 14'h044);
    tick(1);
    check("t5_rst_ack", OW'(ack), OW'(4'b0000));
    check("t5_rst_grant", OW'(grant), OW'(4'b0000));
    check("t5_rst_strobe", OW'(strobe), OW'(16'h0000));
    check("t5_rst_bus", obus, '0);
    rstn = 1'b1;
    tick(1);
    check("t5_post_rst_grant", OW'(grant), OW'(4'b0001));
    tick(1);
    req[0] = 1'b0;
    tick(2);
    req[2] = 1'b0;

    // Full-scale data to the top port
    set_req(1, 1'b1, 4'd15, 14'h3FFF);
    tick(2);
    req[1] = 1'b0;
    tick(1);
    check("t6_out15", OW'(sl(obus, 15)), OW'(14'h3FFF));
    check("t6_out14", OW'(sl(obus, 14)), OW'(14'h0000));
    check("t6_bus", obus, put(put(put('0, 1, 14'h3FFF), 4, 14'h044), 15, 14'h3FFF));
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
